// File: rtl/alu16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu16_pkg : shared types and constants for the ALU16 datapath        |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package alu16_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_divider_if : start/busy/done handshake and operand/result bus    |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
interface seq_divider_if
  import alu16_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             signed_op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor, signed_op,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, signed_op,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | subtractor : a - b with borrow-out and signed overflow flag          |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module subtractor #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};
  assign overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_divider : restoring divider, one quotient bit per clock.         |
// | Define DIV_SIGNED_EN to honour signed_op (two's-complement division) |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module seq_divider
  import alu16_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

  div_state_t         r_state;
  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_dvsr;
  logic               r_dz;

  logic [WIDTH-1:0]   w_shifted;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_dd_mag;
  logic [WIDTH-1:0]   w_ds_mag;
  logic               w_borrow;
  logic               w_ovf;
  logic               w_take;
  logic               w_unused;

  assign w_shifted = {r_rem[WIDTH-2:0], r_work[WIDTH-1]};

  subtractor #(.WIDTH(WIDTH)) u_sub (
    .a        (w_shifted),
    .b        (r_dvsr),
    .diff     (w_diff),
    .borrow   (w_borrow),
    .overflow (w_ovf)
  );

  // A bit shifted out of the partial remainder means the true shifted value
  // is >= 2^WIDTH, which always exceeds the divisor; the wrapped diff is exact.
  assign w_take = ~w_borrow | r_rem[WIDTH-1];

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_neg_dd;
  logic w_neg_ds;

  assign w_neg_dd = bus.signed_op & bus.dividend[WIDTH-1];
  assign w_neg_ds = bus.signed_op & bus.divisor[WIDTH-1];
  assign w_dd_mag = w_neg_dd ? -bus.dividend : bus.dividend;
  assign w_ds_mag = w_neg_ds ? -bus.divisor  : bus.divisor;
`else
  assign w_dd_mag = bus.dividend;
  assign w_ds_mag = bus.divisor;
`endif

  assign w_unused = &{1'b0, w_ovf, bus.signed_op};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_count         <= '0;
      r_rem           <= '0;
      r_work          <= '0;
      r_dvsr          <= '0;
      r_dz            <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q         <= 1'b0;
      r_neg_r         <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_rem    <= '0;
            r_dvsr   <= w_ds_mag;
            r_dz     <= (bus.divisor == '0);
            bus.busy <= 1'b1;
`ifdef DIV_SIGNED_EN
            r_neg_q  <= w_neg_dd ^ w_neg_ds;
            r_neg_r  <= w_neg_dd;
`endif
            // Divide-by-zero keeps the raw dividend for the remainder output
            if (bus.divisor == '0) begin
              r_work  <= bus.dividend;
              r_state <= FIX;
            end else begin
              r_work  <= w_dd_mag;
              r_count <= c_cnt_init;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem   <= w_take ? w_diff : w_shifted;
          r_work  <= {r_work[WIDTH-2:0], w_take};
          r_count <= r_count - 1'b1;
          if (r_count == c_cnt_last) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_dz) begin
            bus.quotient  <= '1;
            bus.remainder <= r_work;
          end else begin
`ifdef DIV_SIGNED_EN
            bus.quotient  <= r_neg_q ? -r_work : r_work;
            bus.remainder <= r_neg_r ? -r_rem  : r_rem;
`else
            bus.quotient  <= r_work;
            bus.remainder <= r_rem;
`endif
          end
          bus.div_by_zero <= r_dz;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
          r_state         <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_divider : directed and randomized checks against an           |
// | arithmetic reference model of the sequential divider                 |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_seq_divider;
  import alu16_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

`ifdef DIV_SIGNED_EN
  bit use_signed = 1'b1;
`else
  bit use_signed = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } res_t;

  function automatic res_t model(input logic [W-1:0] dd, input logic [W-1:0] ds, input logic sop);
    res_t res;
    int   a;
    int   b;
    if (ds == '0) begin
      res.q  = '1;
      res.r  = dd;
      res.dz = 1'b1;
    end else if (sop && use_signed) begin
      a      = int'($signed(dd));
      b      = int'($signed(ds));
      res.q  = W'(a / b);
      res.r  = W'(a % b);
      res.dz = 1'b0;
    end else begin
      res.q  = dd / ds;
      res.r  = dd % ds;
      res.dz = 1'b0;
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference timeline: an accepted request finishes a fixed number of edges later
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  res_t m_out  = '0;
  res_t m_pend = '0;
  int   m_left = 0;
  bit   chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_out  <= '0;
      m_left <= 0;
      chk_en <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
          m_out  <= m_pend;
        end
      end else if (bus.start) begin
        m_pend <= model(bus.dividend, bus.divisor, bus.signed_op);
        m_left <= (bus.divisor == '0) ? 1 : W + 1;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp busy", 32'(bus.busy), 32'(m_busy));
      check("cmp done", 32'(bus.done), 32'(m_done));
      check("cmp quotient", 32'(bus.quotient), 32'(m_out.q));
      check("cmp remainder", 32'(bus.remainder), 32'(m_out.r));
      check("cmp div_by_zero", 32'(bus.div_by_zero), 32'(m_out.dz));
    end
  end

  // Issue one request at a negedge and wait (bounded) for done
  task automatic run_div(input string name, input logic [W-1:0] dd, input logic [W-1:0] ds,
                         input logic sop, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int elat, input bit inject);
    int n;
    int busy_n;
    bus.start     = 1'b1;
    bus.dividend  = dd;
    bus.divisor   = ds;
    bus.signed_op = sop;
    @(negedge clk);
    bus.start = 1'b0;
    n         = 1;
    busy_n    = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_n++;
      if (inject && n == 5) begin
        bus.start    = 1'b1;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check({name, " latency"}, 32'(n - 1), 32'(elat));
    check({name, " busy cycles"}, 32'(busy_n), 32'(elat));
    check({name, " quotient"}, 32'(bus.quotient), 32'(eq));
    check({name, " remainder"}, 32'(bus.remainder), 32'(er));
    check({name, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edz));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.signed_op = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset quotient", 32'(bus.quotient), 32'd0);
    check("reset remainder", 32'(bus.remainder), 32'd0);
    check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);

    run_div("100/7", 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 17, 1'b0);
    run_div("ffff/1", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 17, 1'b0);
    run_div("5/9", 16'h0005, 16'h0009, 1'b0, 16'h0000, 16'h0005, 1'b0, 17, 1'b0);
    run_div("1234/0", 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1, 1'b0);
    run_div("inject", 16'd60001, 16'd250, 1'b0, 16'd240, 16'd1, 1'b0, 17, 1'b1);

    // Abort a division mid-flight
    bus.start    = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort quotient", 32'(bus.quotient), 32'd0);
    check("abort remainder", 32'(bus.remainder), 32'd0);
    run_div("after abort", 16'd1000, 16'd3, 1'b0, 16'd333, 16'd1, 1'b0, 17, 1'b0);

`ifdef DIV_SIGNED_EN
    run_div("-7/2", 16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 17, 1'b0);
    run_div("min/-1", 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 17, 1'b0);
    run_div("7/-2", 16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 17, 1'b0);
`else
    run_div("-7/2 ignored", 16'hFFF9, 16'h0002, 1'b1, 16'h7FFC, 16'h0001, 1'b0, 17, 1'b0);
`endif
    run_div("fff9/2 uns", 16'hFFF9, 16'h0002, 1'b0, 16'h7FFC, 16'h0001, 1'b0, 17, 1'b0);
    run_div("8000/ffff uns", 16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 17, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      bus.start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: begin bus.dividend = W'($urandom); bus.divisor = '0; end
        1: begin bus.dividend = W'($urandom); bus.divisor = 16'h0001; end
        2: begin bus.dividend = W'($urandom); bus.divisor = W'($urandom_range(1, 15)); end
        3: begin bus.dividend = 16'h8000; bus.divisor = 16'hFFFF; end
        default: begin bus.dividend = W'($urandom); bus.divisor = W'($urandom); end
      endcase
      bus.signed_op = $urandom_range(0, 1) == 1;
      @(negedge clk);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (25) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider for the ALU16 datapath. Computes quotient and remainder of two WIDTH-bit operands at one quotient bit per clock. The per-iteration trial subtraction is done by an instantiated `subtractor`, and its `borrow` output is the restore decision. It sits beside the combinational ALU ops as the multi-cycle DIV/MOD unit and uses a start/busy/done handshake.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width (≥2).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a division. Accepted only when `busy`=0.
- `dividend`  in  WIDTH: numerator, sampled on the accepting edge.
- `divisor`  in  WIDTH: denominator, sampled on the accepting edge.
- `signed_op`  in  1: two's-complement division. Sampled on the accepting edge. Ignored unless `DIV_SIGNED_EN` is defined.
- `busy`  out  1: operation in flight (states CALC, FIX).
- `done`  out  1: single-cycle pulse when results update.
- `quotient`  out  WIDTH: registered result, held until the next `done`.
- `remainder`  out  WIDTH: registered result, held until the next `done`.
- `div_by_zero`  out  1: registered flag, valid with `done`, held with the results.

## Operation
- States: IDLE, CALC, FIX. Reset → IDLE.
- Reset values:
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - Iteration counter=0.
- IDLE:
  - On `start`: latch operand magnitudes (unsigned: as given), latch the sign flags, and clear the partial remainder.
  - If `divisor`==0 → FIX; otherwise → CALC with count=WIDTH.
- CALC, per cycle:
  - Shift {partial_rem, work_q} left by 1.
  - `subtractor` computes shifted_rem − divisor.
  - If `borrow`=0: partial_rem ← diff and the new q LSB=1. Else: keep shifted_rem and q LSB=0.
  - Decrement count; at count==1 → FIX.
  - `subtractor.overflow` is unused.
- FIX, one cycle:
  - Register `quotient`, `remainder` and `div_by_zero`.
  - Assert `done`=1 and go → IDLE.
- Divide by zero:
  - `quotient`=all ones, `remainder`=dividend as given, `div_by_zero`=1.
  - No sign correction is applied in this case.
- Signed (macro on, `signed_op`=1):
  - Quotient negated if the operand signs differ.
  - Remainder takes the dividend's sign (truncating division).
  - Most-negative / −1 yields `quotient`=most-negative, `remainder`=0, with no extra flag.
- `start` while `busy`=1 is ignored; the operand inputs are don't-care.
- `rst` asserted in any state: next edge → IDLE, all outputs take their reset values, and no `done` is produced.

## Timing
- Let E0 be the edge that accepts `start`. `busy`=1 from after E0.
- Normal division:
  - CALC iterations on edges E1…E_WIDTH.
  - FIX registers the results on E_{WIDTH+1}, so `done`=1 and new results are visible in the cycle after E_{WIDTH+1}.
  - Latency is WIDTH+1 cycles (17 for WIDTH=16).
- Divide by zero: FIX on E1, so latency is 1 cycle.
- `busy` deasserts on the same edge `done` asserts.
- A `start` in the `done` cycle is accepted, giving back-to-back throughput of one result per WIDTH+2 cycles.
- `done` is high for exactly one cycle.

## Configuration
- `DIV_SIGNED_EN` defined:
  - `signed_op` is honoured.
  - Magnitude conversion happens on accept; sign correction of quotient and remainder happens in FIX.
- Not defined:
  - `signed_op` is ignored and all division is unsigned.
  - The negation logic is not built.
  - The port list is identical in both cases.

## Structure
- Shared package (`alu16_pkg`):
  - State encoding typedef `div_state_t` (IDLE, CALC, FIX).
  - Default width constant `ALU_WIDTH`=16.
- One sub-module instance: the existing `subtractor #(WIDTH)`, used for the trial subtraction.
- Counter, shift registers and sign handling stay inline.

## Test plan
- Unsigned 100 / 7 → after 17 cycles `done`=1, `quotient`=14, `remainder`=2, `div_by_zero`=0. `busy` high for exactly 17 cycles.
- Unsigned 0xFFFF / 0x0001 → `quotient`=0xFFFF, `remainder`=0. Then 0x0005 / 0x0009 → `quotient`=0, `remainder`=5.
- 0x1234 / 0 → `done` one cycle after accept, `quotient`=0xFFFF, `remainder`=0x1234, `div_by_zero`=1.
- `DIV_SIGNED_EN` on:
  - −7 / 2 → `quotient`=0xFFFD, `remainder`=0xFFFF.
  - 0x8000 / 0xFFFF → `quotient`=0x8000, `remainder`=0.
  - Same operands with `signed_op`=0 → unsigned results.
- Pulse `start` with new operands during CALC → ignored; the original result is delivered on schedule.
- `rst` at iteration 5 → no `done`, outputs zero. A new `start` on the next cycle completes correctly.
